// File: rtl/itype_window.sv
// Three-slot instruction window (previous / current / next) that feeds
// itype_detector. Beats from the core shift in at the next-slot end. A drain
// request pushes bubbles through until the window is empty.

package trdb_pkg;
  localparam int XLEN = 32;
endpackage

module itype_window #(
  parameter int XLEN = trdb_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // retired-instruction beat from the core
  input  logic            valid_i,
  input  logic [XLEN-1:0] iaddr_i,
  input  logic [XLEN-1:0] inst_data_i,
  input  logic            compressed_i,
  input  logic            exception_i,
  input  logic            interrupt_i,
  input  logic            eret_i,
  output logic            ready_o,
  input  logic            drain_i,
  // previous slot
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_iaddr_o,
  // current slot
  output logic            cc_valid_o,
  output logic [XLEN-1:0] cc_iaddr_o,
  output logic [XLEN-1:0] cc_inst_data_o,
  output logic            cc_compressed_o,
  output logic            cc_exception_o,
  output logic            cc_interrupt_o,
  output logic            cc_eret_o,
  // next slot
  output logic            nc_valid_o,
  output logic [XLEN-1:0] nc_iaddr_o,
  // downstream handshake
  output logic            out_valid_o,
  input  logic            ready_i,
  output logic            drain_done_o
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] iaddr;
    logic [XLEN-1:0] inst_data;
    logic            compressed;
    logic            exception;
    logic            interrupt;
    logic            eret;
  } slot_t;

  state_e          state_q, state_d;
  slot_t           nc_q, nc_d;
  slot_t           cc_q, cc_d;
  logic            pc_valid_q, pc_valid_d;
  logic [XLEN-1:0] pc_iaddr_q, pc_iaddr_d;
  logic            drain_done_q, drain_done_d;

  logic  draining;
  logic  window_valid;
  logic  accept_ready;
  logic  accept;
  slot_t beat;

  // Handshake signals derived from the registered window.
  always_comb begin
    draining     = (state_q == S_DRAIN);
    window_valid = draining ? cc_q.valid : (cc_q.valid && nc_q.valid);
    accept_ready = !draining && (!window_valid || ready_i);
    accept       = valid_i && accept_ready;
    beat         = '{valid:      1'b1,
                     iaddr:      iaddr_i,
                     inst_data:  inst_data_i,
                     compressed: compressed_i,
                     exception:  exception_i,
                     interrupt:  interrupt_i,
                     eret:       eret_i};
  end

  // Next-state and slot-shift logic.
  always_comb begin
    // NOTE: every target gets a default first so no path can hold a value
    // combinationally and infer a latch.
    state_d      = state_q;
    nc_d         = nc_q;
    cc_d         = cc_q;
    pc_valid_d   = pc_valid_q;
    pc_iaddr_d   = pc_iaddr_q;
    drain_done_d = 1'b0;

    if (draining) begin
      if (!cc_q.valid && !nc_q.valid) begin
        // Window fully flushed: close out the trace.
        state_d      = S_EMPTY;
        pc_valid_d   = 1'b0;
        pc_iaddr_d   = '0;
        drain_done_d = 1'b1;
      end else if (!window_valid || ready_i) begin
        pc_valid_d = cc_q.valid;
        pc_iaddr_d = cc_q.iaddr;
        cc_d       = nc_q;
        nc_d       = '0;
      end
    end else begin
      if (accept) begin
        pc_valid_d = cc_q.valid;
        pc_iaddr_d = cc_q.iaddr;
        cc_d       = nc_q;
        nc_d       = beat;
        case (state_q)
          S_EMPTY: state_d = S_FILL;
          default: state_d = S_RUN;
        endcase
      end
      // A beat arriving with the drain request is taken first, so the
      // window is non-empty and must be drained.
      if (drain_i) begin
        if (accept || state_q != S_EMPTY) begin
          state_d = S_DRAIN;
        end else begin
          drain_done_d = 1'b1;
        end
      end
    end
  end

  // State and slot registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_EMPTY;
      nc_q         <= '0;
      cc_q         <= '0;
      pc_valid_q   <= 1'b0;
      pc_iaddr_q   <= '0;
      drain_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, which is what makes the slot shift a clean pipeline.
      state_q      <= state_d;
      nc_q         <= nc_d;
      cc_q         <= cc_d;
      pc_valid_q   <= pc_valid_d;
      pc_iaddr_q   <= pc_iaddr_d;
      drain_done_q <= drain_done_d;
    end
  end

  // Slot outputs come straight from registers; handshake is forced to its
  // idle values while reset is held.
  assign pc_valid_o      = pc_valid_q;
  assign pc_iaddr_o      = pc_iaddr_q;
  assign cc_valid_o      = cc_q.valid;
  assign cc_iaddr_o      = cc_q.iaddr;
  assign cc_inst_data_o  = cc_q.inst_data;
  assign cc_compressed_o = cc_q.compressed;
  assign cc_exception_o  = cc_q.exception;
  assign cc_interrupt_o  = cc_q.interrupt;
  assign cc_eret_o       = cc_q.eret;
  assign nc_valid_o      = nc_q.valid;
  assign nc_iaddr_o      = nc_q.iaddr;
  assign out_valid_o     = !rst_i && window_valid;
  assign ready_o         = rst_i || accept_ready;
  assign drain_done_o    = drain_done_q;

endmodule

// File: tb/tb_itype_window.sv
// Directed, table-driven bench for itype_window. Each record gives the
// inputs for one cycle plus the outputs expected during that same cycle
// (sampled just after the falling edge, before the next rising edge).

module tb_itype_window;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic [XLEN-1:0] iaddr_i;
  logic [XLEN-1:0] inst_data_i;
  logic            compressed_i, exception_i, interrupt_i, eret_i;
  logic            ready_o, drain_i;
  logic            pc_valid_o;
  logic [XLEN-1:0] pc_iaddr_o;
  logic            cc_valid_o;
  logic [XLEN-1:0] cc_iaddr_o, cc_inst_data_o;
  logic            cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o;
  logic            nc_valid_o;
  logic [XLEN-1:0] nc_iaddr_o;
  logic            out_valid_o, ready_i, drain_done_o;

  int checks = 0;
  int errors = 0;

  itype_window #(.XLEN(XLEN)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .iaddr_i        (iaddr_i),
    .inst_data_i    (inst_data_i),
    .compressed_i   (compressed_i),
    .exception_i    (exception_i),
    .interrupt_i    (interrupt_i),
    .eret_i         (eret_i),
    .ready_o        (ready_o),
    .drain_i        (drain_i),
    .pc_valid_o     (pc_valid_o),
    .pc_iaddr_o     (pc_iaddr_o),
    .cc_valid_o     (cc_valid_o),
    .cc_iaddr_o     (cc_iaddr_o),
    .cc_inst_data_o (cc_inst_data_o),
    .cc_compressed_o(cc_compressed_o),
    .cc_exception_o (cc_exception_o),
    .cc_interrupt_o (cc_interrupt_o),
    .cc_eret_o      (cc_eret_o),
    .nc_valid_o     (nc_valid_o),
    .nc_iaddr_o     (nc_iaddr_o),
    .out_valid_o    (out_valid_o),
    .ready_i        (ready_i),
    .drain_done_o   (drain_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, v;
    logic [31:0] a;
    logic        exc, cmp, drn, rdy;
    logic        e_ro, e_ov, e_ccv;
    logic [31:0] e_cca;
    logic        e_ncv;
    logic [31:0] e_nca;
    logic        e_pcv;
    logic [31:0] e_pca;
    logic        e_dd, e_ccx, e_ccc;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step, act, exp);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then compare.
  task automatic apply(input vec_t t, input int step);
    @(negedge clk_i);
    rst_i        = t.rst;
    valid_i      = t.v;
    iaddr_i      = t.a;
    inst_data_i  = ~t.a;
    exception_i  = t.exc;
    compressed_i = t.cmp;
    interrupt_i  = 1'b0;
    eret_i       = 1'b0;
    drain_i      = t.drn;
    ready_i      = t.rdy;
    #1;
    check("ready_o",      step, 32'(ready_o),      32'(t.e_ro));
    check("out_valid_o",  step, 32'(out_valid_o),  32'(t.e_ov));
    check("cc_valid_o",   step, 32'(cc_valid_o),   32'(t.e_ccv));
    check("cc_iaddr_o",   step, cc_iaddr_o,        t.e_cca);
    check("cc_inst_data", step, cc_inst_data_o,    t.e_ccv ? ~t.e_cca : 32'h0);
    check("cc_exception", step, 32'(cc_exception_o), 32'(t.e_ccx));
    check("cc_compressed",step, 32'(cc_compressed_o),32'(t.e_ccc));
    check("cc_int_eret",  step, 32'({cc_interrupt_o, cc_eret_o}), 32'h0);
    check("nc_valid_o",   step, 32'(nc_valid_o),   32'(t.e_ncv));
    check("nc_iaddr_o",   step, nc_iaddr_o,        t.e_nca);
    check("pc_valid_o",   step, 32'(pc_valid_o),   32'(t.e_pcv));
    check("pc_iaddr_o",   step, pc_iaddr_o,        t.e_pca);
    check("drain_done_o", step, 32'(drain_done_o), 32'(t.e_dd));
  endtask

  initial begin
    //          rst v  addr          exc cmp drn rdy  ro ov ccv cca           ncv nca           pcv pca           dd ccx ccc
    // reset: beat offered while in reset must not be taken
    tbl[0]  = '{1, 1, 32'hDEAD,      0, 0, 0, 1,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0};
    // fill A, B, C
    tbl[1]  = '{0, 1, 32'h100,       0, 0, 0, 1,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0};
    tbl[2]  = '{0, 1, 32'h104,       0, 0, 0, 1,  1, 0, 0, 32'h0,        1, 32'h100,      0, 32'h0,        0, 0, 0};
    tbl[3]  = '{0, 1, 32'h108,       0, 0, 0, 1,  1, 1, 1, 32'h100,      1, 32'h104,      0, 32'h0,        0, 0, 0};
    // stall three cycles with 0x10C offered
    tbl[4]  = '{0, 1, 32'h10C,       0, 0, 0, 0,  0, 1, 1, 32'h104,      1, 32'h108,      1, 32'h100,      0, 0, 0};
    tbl[5]  = '{0, 1, 32'h10C,       0, 0, 0, 0,  0, 1, 1, 32'h104,      1, 32'h108,      1, 32'h100,      0, 0, 0};
    tbl[6]  = '{0, 1, 32'h10C,       0, 0, 0, 0,  0, 1, 1, 32'h104,      1, 32'h108,      1, 32'h100,      0, 0, 0};
    tbl[7]  = '{0, 1, 32'h10C,       0, 0, 0, 1,  1, 1, 1, 32'h104,      1, 32'h108,      1, 32'h100,      0, 0, 0};
    // event flag beat 0x300 followed by 0x80000000
    tbl[8]  = '{0, 1, 32'h300,       1, 0, 0, 1,  1, 1, 1, 32'h108,      1, 32'h10C,      1, 32'h104,      0, 0, 0};
    tbl[9]  = '{0, 1, 32'h80000000,  0, 0, 0, 1,  1, 1, 1, 32'h10C,      1, 32'h300,      1, 32'h108,      0, 0, 0};
    tbl[10] = '{0, 1, 32'h200,       0, 0, 0, 1,  1, 1, 1, 32'h300,      1, 32'h80000000, 1, 32'h10C,      0, 1, 0};
    tbl[11] = '{0, 1, 32'h202,       0, 1, 0, 1,  1, 1, 1, 32'h80000000, 1, 32'h200,      1, 32'h300,      0, 0, 0};
    // drain pulse with cc=0x200, nc=0x202 (compressed)
    tbl[12] = '{0, 0, 32'h0,         0, 0, 1, 1,  1, 1, 1, 32'h200,      1, 32'h202,      1, 32'h80000000, 0, 0, 0};
    tbl[13] = '{0, 0, 32'h0,         0, 0, 0, 1,  0, 1, 1, 32'h200,      1, 32'h202,      1, 32'h80000000, 0, 0, 0};
    tbl[14] = '{0, 0, 32'h0,         0, 0, 0, 1,  0, 1, 1, 32'h202,      0, 32'h0,        1, 32'h200,      0, 0, 1};
    tbl[15] = '{0, 0, 32'h0,         0, 0, 0, 1,  0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h202,      0, 0, 0};
    tbl[16] = '{0, 0, 32'h0,         0, 0, 0, 1,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 0};
    tbl[17] = '{0, 0, 32'h0,         0, 0, 0, 1,  1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 0};

    rst_i = 1'b1; valid_i = 1'b0; iaddr_i = '0; inst_data_i = '0;
    compressed_i = 1'b0; exception_i = 1'b0; interrupt_i = 1'b0; eret_i = 1'b0;
    drain_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 18; i++) apply(tbl[i], i);

    // Drain request while empty: single done pulse, stays empty.
    apply('{0, 0, 32'h0,   0, 0, 1, 1,  1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 0, 0}, 100);
    apply('{0, 0, 32'h0,   0, 0, 0, 1,  1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 1, 0, 0}, 101);
    apply('{0, 0, 32'h0,   0, 0, 0, 1,  1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 0, 0}, 102);

    // Beat and drain together in FILL: beat taken, then draining.
    apply('{0, 1, 32'h500, 0, 0, 0, 1,  1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 0, 0}, 200);
    apply('{0, 1, 32'h400, 0, 0, 1, 1,  1, 0, 0, 32'h0,   1, 32'h500, 0, 32'h0, 0, 0, 0}, 201);
    // In DRAIN: ready_o low even with a beat offered; downstream stalls.
    apply('{0, 1, 32'h600, 0, 0, 0, 0,  0, 1, 1, 32'h500, 1, 32'h400, 0, 32'h0, 0, 0, 0}, 202);
    // Reset asserted mid-drain: handshake idles immediately.
    apply('{1, 0, 32'h0,   0, 0, 0, 0,  1, 0, 1, 32'h500, 1, 32'h400, 0, 32'h0, 0, 0, 0}, 203);
    // Slots discarded, no done pulse afterwards.
    apply('{0, 0, 32'h0,   0, 0, 0, 1,  1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 0, 0}, 204);
    apply('{0, 0, 32'h0,   0, 0, 0, 1,  1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 0, 0}, 205);
    apply('{0, 0, 32'h0,   0, 0, 0, 1,  1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0, 0, 0, 0}, 206);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/itype_window.md
ITYPE_WINDOW -- requirements
Module: itype_window

Interface
REQ-001 SHALL have parameter XLEN, default trdb_pkg::XLEN, address and instruction-data width.
REQ-002 SHALL have port clk_i  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports valid_i, iaddr_i[XLEN-1:0], inst_data_i[XLEN-1:0], compressed_i, exception_i, interrupt_i, eret_i  in  retired-instruction beat from the core.
REQ-005 SHALL have port ready_o  out  1  beat accepted when valid_i && ready_o.
REQ-006 SHALL have port drain_i  in  1  single-cycle pulse: end of trace, flush remaining window.
REQ-007 SHALL have ports pc_valid_o, pc_iaddr_o  out  previous slot.
REQ-008 SHALL have ports cc_valid_o, cc_iaddr_o, cc_inst_data_o, cc_compressed_o, cc_exception_o, cc_interrupt_o, cc_eret_o  out  current slot.
REQ-009 SHALL have ports nc_valid_o, nc_iaddr_o  out  next slot.
REQ-010 SHALL have port out_valid_o  out  1  window presentable to itype_detector.
REQ-011 SHALL have port ready_i  in  1  downstream consumed current window.
REQ-012 SHALL have port drain_done_o  out  1  one-cycle pulse when drain completes.

Function
REQ-013 SHALL hold three slots nc, cc, pc, each a stored valid bit plus payload; nc and cc store the full beat; pc stores valid and address only.
REQ-014 SHALL shift on a shift event: pc <= cc (valid, iaddr), cc <= nc, nc <= incoming beat or, when draining, a bubble (valid 0, payload 0).
REQ-015 SHALL implement FSM states EMPTY, FILL, RUN, DRAIN.
REQ-016 EMPTY: no slot valid; accepted beat -> FILL.
REQ-017 FILL: only nc valid; accepted beat -> RUN.
REQ-018 RUN: cc and nc valid; out_valid_o = 1; stays RUN on accepted beat.
REQ-019 drain_i in FILL or RUN SHALL enter DRAIN next cycle; drain_i in EMPTY SHALL pulse drain_done_o next cycle and stay EMPTY; drain_i in DRAIN SHALL be ignored.
REQ-020 DRAIN: ready_o = 0; shift a bubble each cycle where !out_valid_o || ready_i; out_valid_o = cc_valid.
REQ-021 DRAIN SHALL exit to EMPTY in the cycle after cc and nc both become invalid, clearing pc_valid and pulsing drain_done_o for exactly one cycle.
REQ-022 Outside DRAIN: out_valid_o = cc_valid && nc_valid; ready_o = !out_valid_o || ready_i (combinational, no bubble on back-to-back beats).
REQ-023 If out_valid_o && !ready_i, all slots and outputs SHALL hold stable.
REQ-024 valid_i && drain_i in the same cycle with ready_o = 1: beat SHALL be accepted first, then DRAIN entered.
REQ-025 Slot outputs SHALL be driven directly from registers; zero combinational path valid_i -> slot outputs.
REQ-026 Sustained throughput SHALL be one beat per cycle when ready_i = 1.

Reset
REQ-027 While rst_i = 1, state SHALL be EMPTY, all slot valid bits and payloads 0, out_valid_o = 0, drain_done_o = 0, ready_o = 1.
REQ-028 rst_i asserted mid-DRAIN or mid-stall SHALL discard all slots with no drain_done_o pulse.

Verification
REQ-029 Fill: beats A=0x100, B=0x104, C=0x108 on consecutive cycles, ready_i=1 -> out_valid_o rises after B is accepted; then cc=0x104, nc=0x108, pc=0x100.
REQ-030 Stall: RUN with cc=0x104, ready_i=0 for 3 cycles, valid_i=1 with 0x10C -> ready_o=0, outputs unchanged 3 cycles; ready_i=1 -> 0x10C accepted, cc=0x108.
REQ-031 Drain: RUN with cc=0x200, nc=0x202 (compressed), drain_i pulse -> window cc=0x200/nc=0x202, then cc=0x202 with nc_valid=0, then EMPTY with drain_done_o=1 for one cycle.
REQ-032 Event flags: beat 0x300 with exception_i=1, then 0x80000000 -> cc_exception_o=1 while cc=0x300 and nc=0x80000000.
REQ-033 Reset mid-drain: rst_i=1 during DRAIN -> all valids 0 next cycle, no drain_done_o, ready_o=1.
REQ-034 Simultaneous: valid_i=1 (0x400) and drain_i=1 in FILL -> 0x400 accepted, cc=prior nc, nc=0x400, state DRAIN.
